// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with two prioritised write ports and init sequencer
module regfile_mp #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic                     init_busy,
    output logic                     wr_conflict
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t              state, state_nx;
    logic [ADDR_W-1:0]   cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   init_val;
    logic                eff0, eff1, same_addr;
    logic [ADDR_W-1:0]   ra;
    logic [DATA_W-1:0]   lane;

    assign init_busy = (state == ST_INIT);
    assign same_addr = (waddr0 == waddr1);

    // Writes to a hardwired entry 0 are not effective at all, so they never conflict.
    assign eff0 = we0 && (state == ST_RUN) && !((ZERO_REG != 0) && (waddr0 == '0));
    assign eff1 = we1 && (state == ST_RUN) && !((ZERO_REG != 0) && (waddr1 == '0));

    always_comb begin
        init_val = '0;
        if (INIT_MODE == 1)
            init_val = DATA_W'(cnt);
    end

    always_comb begin
        state_nx = state;
        if (reset)
            state_nx = ST_INIT;
        else if (state == ST_INIT && cnt == ADDR_W'(DEPTH - 1))
            state_nx = ST_RUN;
    end

    always_ff @(posedge clk) begin
        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= eff0 && eff1 && same_addr;
            if (state == ST_INIT) begin
                mem[cnt] <= init_val;
                cnt      <= cnt + 1'b1;
            end else begin
                // Port 1 is written last so it wins a same-address collision.
                if (eff0)
                    mem[waddr0] <= wdata0;
                if (eff1)
                    mem[waddr1] <= wdata1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        ra    = '0;
        lane  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra   = raddr[k*ADDR_W +: ADDR_W];
            lane = mem[ra];
            if (BYPASS != 0) begin
                if (eff0 && waddr0 == ra)
                    lane = wdata0;
                if (eff1 && waddr1 == ra)
                    lane = wdata1;
            end
            if ((ZERO_REG != 0) && ra == '0)
                lane = '0;
            if (init_busy)
                lane = '0;
            rdata[k*DATA_W +: DATA_W] = lane;
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;
    logic         clk = 1'b0;
    logic         reset;
    logic         we0, we1;
    logic [4:0]   waddr0, waddr1;
    logic [31:0]  wdata0, wdata1;
    logic [19:0]  raddr_a;
    logic [127:0] rdata_a;
    logic         busy_a, conf_a;
    logic [9:0]   raddr_b;
    logic [63:0]  rdata_b;
    logic         busy_b, conf_b;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n;

    always #5 clk = ~clk;

    // Instance a: debug init, bypass on, four read lanes.
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1), .INIT_MODE(1)) dut_a (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr_a), .rdata(rdata_a),
        .init_busy(busy_a), .wr_conflict(conf_a)
    );

    // Instance b: zero init, no bypass, two read lanes.
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0), .INIT_MODE(0)) dut_b (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr_b), .rdata(rdata_b),
        .init_busy(busy_b), .wr_conflict(conf_b)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0;
        we1 = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        raddr_a = {15'd0, a};
        raddr_b = {5'd0, a};
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        raddr_a = '0; raddr_b = '0;
        repeat (3) tick();
        check("reset_busy", busy_a, 1);
        check("reset_conf", conf_a, 0);
        reset = 1'b0;

        // Init sequence; a write lands in the cycle of the final init edge.
        n = 0;
        while (busy_a && n < 100) begin
            if (n == 20) begin
                rd(7);
                check("busy_reads_zero", rdata_a[31:0], 0);
            end
            if (n == 31) begin
                we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h4444_0004;
            end
            tick();
            n++;
        end
        idle();
        check("init_edges", n, 32);
        check("busy_b_low", busy_b, 0);
        rd(7);  check("init_a7", rdata_a[31:0], 7);
        rd(31); check("init_a31", rdata_a[31:0], 31);
        rd(0);  check("init_a0", rdata_a[31:0], 0);
        rd(4);
        check("edge_write_dropped_a", rdata_a[31:0], 4);
        check("edge_write_dropped_b", rdata_b[31:0], 0);
        we0 = 1'b1; waddr0 = 5'd4; wdata0 = 32'h4444_0004;
        tick();
        idle();
        rd(4);
        check("first_write_a", rdata_a[31:0], 32'h4444_0004);
        check("first_write_b", rdata_b[31:0], 32'h4444_0004);

        // Bypass versus array latency.
        rd(5);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        #1;
        check("bypass_same_cycle", rdata_a[31:0], 32'hDEAD_BEEF);
        check("nobypass_old", rdata_b[31:0], 0);
        tick();
        idle();
        #1;
        check("bypass_next", rdata_a[31:0], 32'hDEAD_BEEF);
        check("nobypass_next", rdata_b[31:0], 32'hDEAD_BEEF);

        // Same-address conflict.
        rd(9);
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h2222_2222;
        #1;
        check("bypass_prio", rdata_a[31:0], 32'h2222_2222);
        check("conf_before", conf_a, 0);
        tick();
        idle();
        #1;
        check("conf_pulse_a", conf_a, 1);
        check("conf_pulse_b", conf_b, 1);
        check("prio_a", rdata_a[31:0], 32'h2222_2222);
        check("prio_b", rdata_b[31:0], 32'h2222_2222);
        tick();
        check("conf_one_cycle", conf_a, 0);

        // Conflict on hardwired zero register.
        rd(0);
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h1111_1111;
        we1 = 1'b1; waddr1 = 5'd0; wdata1 = 32'h2222_2222;
        #1;
        check("zero_bypass", rdata_a[31:0], 0);
        tick();
        idle();
        #1;
        check("zero_no_conf", conf_a, 0);
        check("zero_a", rdata_a[31:0], 0);
        check("zero_b", rdata_b[31:0], 0);

        // Both ports, distinct addresses.
        we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'h10;
        we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'h11;
        tick();
        idle();
        check("distinct_no_conf", conf_a, 0);
        rd(10); check("distinct_p0", rdata_b[31:0], 32'h10);
        rd(11); check("distinct_p1", rdata_b[31:0], 32'h11);

        // Concurrent multi-lane reads.
        we0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'hA;
        we1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'hB;
        tick();
        we1 = 1'b0;
        waddr0 = 5'd3; wdata0 = 32'hC;
        tick();
        idle();
        raddr_a = {5'd1, 5'd3, 5'd2, 5'd1};
        raddr_b = {5'd2, 5'd1};
        #1;
        check("four_lanes", rdata_a, {32'hA, 32'hC, 32'hB, 32'hA});
        check("two_lanes", rdata_b, {64'h0000_000B_0000_000A});

        // Reset during a conflicting write clears the pulse.
        we0 = 1'b1; waddr0 = 5'd12; wdata0 = 32'h1;
        we1 = 1'b1; waddr1 = 5'd12; wdata1 = 32'h2;
        reset = 1'b1;
        tick();
        idle();
        reset = 1'b0;
        check("reset_conf_clear", conf_a, 0);
        check("reset_busy_again", busy_a, 1);
        repeat (10) tick();

        // Mid-sequence reset restarts init; a write during init is dropped.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("restart_busy", busy_a, 1);
        n = 0;
        while (busy_a && n < 100) begin
            if (n == 10) begin
                we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h3333_3333;
            end else begin
                idle();
            end
            tick();
            n++;
        end
        idle();
        check("restart_edges", n, 32);
        rd(3);
        check("init_write_dropped_a", rdata_a[31:0], 3);
        check("init_write_dropped_b", rdata_b[31:0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipeline's decode/write-back stages. It replaces the single-write, level-sensitive register array with clocked writes, two write ports with fixed priority, and a configurable number of combinational read ports. Optional write-to-read bypass and a hardwired zero register are included. After reset, a sequencer initialises every entry over several cycles and reports progress on `init_busy`.

## Interface
Parameters:
- `DATA_W`, 32: register width in bits.
- `ADDR_W`, 5: address width; depth `DEPTH` = 2^ADDR_W.
- `NUM_RD`, 2: number of read ports, legal range 1..4.
- `ZERO_REG`, 1: when 1, entry 0 is hardwired to zero.
- `BYPASS`, 1: when 1, a same-cycle write is forwarded to matching reads.
- `INIT_MODE`, 0: initial contents; 0 loads all zeros, 1 loads each entry with its own index (zero-extended), for debug.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `we0`  in  1  write enable, port 0.
- `waddr0`  in  ADDR_W  write address, port 0.
- `wdata0`  in  DATA_W  write data, port 0.
- `we1`  in  1  write enable, port 1. Port 1 has priority over port 0.
- `waddr1`  in  ADDR_W  write address, port 1.
- `wdata1`  in  DATA_W  write data, port 1.
- `raddr`  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- `rdata`  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]. Combinational.
- `init_busy`  out  1  high while the initialisation sequence runs; writes are ignored while high.
- `wr_conflict`  out  1  registered one-cycle pulse when both write ports hit the same effective address.

## Operation
The controller has two states, `INIT` and `RUN`.

**INIT state**
- `reset` sampled high moves the block to INIT from any state, including mid-sequence. It also clears the init counter `cnt` to 0 and clears `wr_conflict` to 0.
- While `reset` stays high, `cnt` holds at 0 and no entry is written.
- Each rising edge with `reset` low writes entry `cnt` with the init value, then increments `cnt`.
- The init value is 0 when `INIT_MODE`=0, and `cnt` when `INIT_MODE`=1.
- The edge that writes entry DEPTH-1 also moves the block to RUN.
- Reset asserted mid-sequence restarts the sequence from entry 0.
- `init_busy` is 1 in INIT and 0 in RUN.

**Read data during INIT**
- All `rdata` lanes read 0 while `init_busy` is 1.

**Writes in RUN**
- A port's write is effective when its `we` is 1, the block is in RUN, and the write is not to entry 0 while `ZERO_REG`=1.
- On the rising edge, each effective write stores its `wdata` at its `waddr`.
- If both ports are effective at the same address, port 1's data is stored, and `wr_conflict` is 1 for the following cycle.
- Otherwise `wr_conflict` is 0.
- Writes to entry 0 with `ZERO_REG`=1 are discarded and never raise `wr_conflict`.

**Reads in RUN**
- Each read lane is independent and combinational from `raddr` and the current contents.
- When `ZERO_REG`=1, address 0 always reads 0.
- When `BYPASS`=1, a lane whose address matches an effective write in the same cycle returns that write's `wdata`. If both ports match, it returns `wdata1`.
- When `BYPASS`=0, the lane returns the stored (pre-edge) value.

**Reset behaviour of outputs**
- `init_busy`=1 and `wr_conflict`=0 from the first edge with `reset` high.
- `rdata`=0 while busy.
- Array contents are not defined until the INIT sequence completes.

## Timing
- **Reset release:** let edge E0 be the last edge with `reset` high. Edges E1..E_DEPTH write entries 0..DEPTH-1. `init_busy` falls after E_DEPTH; with default parameters that is 32 cycles after reset release.
- **Write-to-read latency:**
  - 1 edge through the array.
  - 0 cycles through the bypass when `BYPASS`=1.
  - A write at edge N is readable from the array in the cycle after edge N.
- **`wr_conflict`:** goes high in the cycle after the conflicting edge and lasts exactly one cycle per conflicting edge.
- **Write during the busy-to-RUN transition:** a write presented in the same cycle as edge E_DEPTH is dropped. The first accepted write is at edge E_DEPTH+1.
- **Critical path:** there is no combinational path from `we`/`wdata` to `rdata` when `BYPASS`=0.

## Test plan
1. Default parameters, `INIT_MODE`=1, reset held 3 cycles then released:
   - `init_busy` stays 1 for 32 edges.
   - Afterwards, reading address 7 gives 7, address 31 gives 31, and address 0 gives 0.
2. Write 0xDEADBEEF to address 5 through port 0 with `BYPASS`=1, with `raddr` lane 0 = 5 in the same cycle:
   - `rdata` lane 0 = 0xDEADBEEF in that cycle and the next.
   - Repeating with `BYPASS`=0 shows the old value in the write cycle and 0xDEADBEEF in the next.
3. Both ports write address 9 in the same cycle, port 0 with 0x11111111 and port 1 with 0x22222222:
   - Address 9 reads 0x22222222.
   - `wr_conflict` is 1 for exactly one cycle.
   - Repeating at address 0 with `ZERO_REG`=1 leaves address 0 reading 0 and `wr_conflict` at 0.
4. Reset asserted at init cycle 10 for 1 cycle:
   - The sequence restarts.
   - `init_busy` stays high 32 further edges.
   - A write attempted to address 3 at cycle 20 is dropped, so address 3 reads its init value.
5. `NUM_RD`=4, four lanes reading addresses 1, 2, 3, 1 after writes of 0xA, 0xB, 0xC to addresses 1, 2, 3:
   - The lanes read 0xA, 0xB, 0xC, 0xA concurrently.
6. Write presented in the same cycle as E_DEPTH:
   - The write is ignored.
   - The same write at E_DEPTH+1 is stored.
